write_back_unit: RTL
====================

WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 16, meaning the number of 8-bit stack entries (power of two, at most 128).
REQ-002 The block SHALL have parameter ESP_INIT, default 8'h10, meaning the esp value after reset and when the stack is empty (equal to STACK_DEPTH).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 wb_start  input  1  single-cycle request to execute one write-back operation.
REQ-006 reg_load  input  4  operation code from decode, sampled with wb_start.
REQ-007 alu_result  input  8  ALU result bus, sampled with wb_start.
REQ-008 ebp  output  8  base-pointer register.
REQ-009 eip  output  8  instruction-pointer register.
REQ-010 esp  output  8  stack-pointer register.
REQ-011 stack_top  output  8  stack[esp], or 8'h00 when the stack is empty (combinational).
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 The operation codes SHALL be as follows: 0 = nop; 1 = push alu_result; 2 = load ebp; 3 and 4 = load eip; 5 = pop into ebp; 6-15 = illegal.
REQ-016 The FSM SHALL use the states IDLE, EXEC, MEM and DONE, with the next state always IDLE after DONE.
REQ-017 In IDLE, wb_start=1 SHALL latch reg_load and alu_result into internal registers and move to EXEC; wb_start=0 SHALL leave the FSM in IDLE.
REQ-018 In EXEC the block SHALL act by code:
  - nop: no change, go to DONE.
  - code 2: ebp <= data, go to DONE.
  - code 3 or 4: eip <= data, go to DONE.
  - push with esp != 0: esp <= esp-1, go to MEM.
  - pop with esp != ESP_INIT: go to MEM.
REQ-019 In MEM the block SHALL act as follows, then go to DONE:
  - push: stack[esp] <= latched data (esp already decremented).
  - pop: ebp <= stack[esp] and esp <= esp+1.
REQ-020 A push when esp == 0 (full) SHALL set err, change no state other than err, and go from EXEC to DONE.
REQ-021 A pop when esp == ESP_INIT (empty) SHALL set err, change no state other than err, and go from EXEC to DONE.
REQ-022 Illegal codes SHALL set err and go from EXEC to DONE.
REQ-023 done SHALL be 1 exactly during the cycle the FSM is in DONE.
REQ-024 busy SHALL be 1 in the EXEC, MEM and DONE states.
REQ-025 If wb_start is sampled at edge k, done SHALL be high in the cycle after:
  - edge k+2 for nop, register and error operations;
  - edge k+3 for a successful push or pop.
REQ-026 wb_start SHALL be ignored when the FSM is not in IDLE; no queuing and no error.
REQ-027 wb_start may be asserted in the DONE cycle; it SHALL be ignored, and it is accepted on the following IDLE cycle.
REQ-028 esp arithmetic SHALL be 8-bit unsigned with no wrap; the full and empty checks prevent wrap.
REQ-029 The stack SHALL be indexed by esp[log2(STACK_DEPTH)-1:0].
REQ-030 Once set, err SHALL stay 1 until reset.
REQ-031 Registers SHALL change only as specified above; all outputs SHALL be glitch-free registered values, except stack_top.

Reset
REQ-032 While reset=1, asynchronously: state=IDLE, ebp=8'h00, eip=8'h00, esp=ESP_INIT, busy=0, done=0, err=0, latched operands=0.
REQ-033 Stack memory contents SHALL NOT be cleared by reset; stack_top SHALL read 8'h00 after reset because the stack is empty.
REQ-034 Reset asserted mid-operation (EXEC or MEM) SHALL abort the operation with no partial register or stack write after reset deasserts, and no done pulse SHALL be produced.
REQ-035 After reset deasserts, the first rising edge with wb_start=1 SHALL be accepted.

Verification
REQ-036 Load ebp: code 2 with data 8'hA5 -> ebp=8'hA5 after edge k+1, done pulse in cycle k+2, eip and esp unchanged.
REQ-037 Push then pop:
  - push 8'h3C -> esp=8'h0F, stack_top=8'h3C, done in cycle k+3.
  - pop -> ebp=8'h3C, esp=8'h10, stack_top=8'h00.
REQ-038 Overflow: 16 pushes of 8'h01..8'h10 (esp=0, stack_top=8'h10), then a 17th push -> err=1, esp stays 0, stack_top stays 8'h10, done in cycle k+2.
REQ-039 Underflow and illegal:
  - pop right after reset -> err=1, ebp=8'h00.
  - a separate run with code 4'hF -> err=1, no register changes.
REQ-040 Busy rejection: a second wb_start (code 3, data 8'h77) during the EXEC of a push -> eip stays 8'h00, exactly one done pulse.
REQ-041 Reset in MEM of a push (data 8'h99) -> esp=8'h10, busy=0, done=0, err=0; a subsequent pop -> err=1.

Source files
------------

// File: rtl/write_back_unit.sv
// Write-back unit: executes one decoded operation per request against the
// ebp/eip/esp register file and a small byte-wide stack growing downward.
module write_back_unit #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter logic [7:0]  ESP_INIT    = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_start,
  input  logic [3:0] reg_load,
  input  logic [7:0] alu_result,
  output logic [7:0] ebp,
  output logic [7:0] eip,
  output logic [7:0] esp,
  output logic [7:0] stack_top,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_PUSH     = 4'd1;
  localparam logic [3:0] OP_LD_EBP   = 4'd2;
  localparam logic [3:0] OP_LD_EIP_A = 4'd3;
  localparam logic [3:0] OP_LD_EIP_B = 4'd4;
  localparam logic [3:0] OP_POP      = 4'd5;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ebp_q, ebp_d;
  logic [7:0] eip_q, eip_d;
  logic [7:0] esp_q, esp_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [7:0] stack_mem [STACK_DEPTH];
  logic [7:0] stack_rd;
  logic       stack_we;
  logic       stack_empty;
  logic       stack_full;

  assign stack_empty = (esp_q == ESP_INIT);
  assign stack_full  = (esp_q == 8'h00);
  assign stack_rd    = stack_mem[esp_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 4'h0;
      data_q  <= 8'h00;
      ebp_q   <= 8'h00;
      eip_q   <= 8'h00;
      esp_q   <= ESP_INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      ebp_q   <= ebp_d;
      eip_q   <= eip_d;
      esp_q   <= esp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (wb_start) state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_PUSH: state_d = stack_full  ? S_DONE : S_MEM;
          OP_POP:  state_d = stack_empty ? S_DONE : S_MEM;
          default: state_d = S_DONE;
        endcase
      end
      S_MEM:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    data_d   = data_q;
    ebp_d    = ebp_q;
    eip_d    = eip_q;
    esp_d    = esp_q;
    err_d    = err_q;
    stack_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_start) begin
          op_d   = reg_load;
          data_d = alu_result;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_NOP: ;
          // Push pre-decrements so esp always points at the live top entry.
          OP_PUSH: begin
            if (stack_full) err_d = 1'b1;
            else            esp_d = esp_q - 8'd1;
          end
          OP_LD_EBP:                ebp_d = data_q;
          OP_LD_EIP_A, OP_LD_EIP_B: eip_d = data_q;
          OP_POP:  if (stack_empty) err_d = 1'b1;
          default: err_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_PUSH) begin
          stack_we = 1'b1;
        end else begin
          ebp_d = stack_rd;
          esp_d = esp_q + 8'd1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: the stack array has no reset; emptiness is tracked by esp alone,
  // which lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (stack_we) stack_mem[esp_q[AW-1:0]] <= data_q;
  end

  assign ebp       = ebp_q;
  assign eip       = eip_q;
  assign esp       = esp_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign stack_top = stack_empty ? 8'h00 : stack_rd;

endmodule
